// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard and interrupt-entry controller for a 5-stage pipe.
// Generates stage write enables and flushes, steers the PC on interrupt
// vectoring and ERET, and tracks pending interrupts and the global enable IE.
// Optional feature macro: PIPE_CTRL_LOAD_USE_EN enables the load-use stall
// detector; without it the load/register inputs are ignored.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       LoadInEx,
  input  logic [4:0] RdEx,
  input  logic [4:0] RsId,
  input  logic [4:0] RtId,
  input  logic       BranchTaken,
  input  logic       EretInId,
  input  logic [3:0] IntReq,
  input  logic [3:0] IntMask,
  input  logic       IeWr,
  input  logic       IeWrData,
  output logic       PCWrite,
  output logic       IfIdWrite,
  output logic       IdExWrite,
  output logic       ExMeWrite,
  output logic       MeWbWrite,
  output logic       IfIdClear,
  output logic       IdExClear,
  output logic       ExMeClear,
  output logic       MeWbClear,
  output logic [1:0] PCSrcOvr,
  output logic       EpcWrite,
  output logic [3:0] IntAck,
  output logic [1:0] IntCause,
  output logic       IeOut
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    VECT  = 2'd3
  } state_t;

  localparam logic [1:0] OVR_NONE = 2'b00;
  localparam logic [1:0] OVR_VEC  = 2'b01;
  localparam logic [1:0] OVR_EPC  = 2'b10;

  state_t     state_q, state_d;
  logic       drain_cnt_q, drain_cnt_d;
  logic [3:0] int_pend_q, int_pend_d;
  logic [1:0] int_cause_q, int_cause_d;
  logic       ie_q, ie_d;

  logic [3:0] int_live;
  logic       int_any;
  logic [1:0] int_win;
  logic       load_use;
  logic       stall_run;

`ifdef PIPE_CTRL_LOAD_USE_EN
  // Load in EX whose destination feeds an ID source: hold one bubble.
  assign load_use = LoadInEx && (RdEx != 5'd0) &&
                    ((RdEx == RsId) || (RdEx == RtId));
`else
  logic unused_load_use_inputs;
  assign load_use               = 1'b0;
  assign unused_load_use_inputs = ^{LoadInEx, RdEx, RsId, RtId};
`endif

  // A taken branch squashes the dependent instruction anyway, and ERET reads
  // no general registers, so either one cancels the stall for that cycle.
  assign stall_run = load_use && !BranchTaken && !EretInId;

  assign int_live = int_pend_q & IntMask;
  assign int_any  = |int_live;

  // Lowest-numbered unmasked pending line wins.
  always_comb begin
    int_win = 2'd0;
    if (int_live[0])      int_win = 2'd0;
    else if (int_live[1]) int_win = 2'd1;
    else if (int_live[2]) int_win = 2'd2;
    else if (int_live[3]) int_win = 2'd3;
  end

  // Next-state, register updates and all pipeline control outputs.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    int_cause_d = int_cause_q;
    ie_d        = ie_q;

    PCWrite   = 1'b1;
    IfIdWrite = 1'b1;
    IdExWrite = 1'b1;
    ExMeWrite = 1'b1;
    MeWbWrite = 1'b1;
    IfIdClear = 1'b0;
    IdExClear = 1'b0;
    ExMeClear = 1'b0;
    MeWbClear = 1'b0;
    PCSrcOvr  = OVR_NONE;
    EpcWrite  = 1'b0;
    IntAck    = 4'b0000;
    IntCause  = int_cause_q;

    if (IeWr) ie_d = IeWrData;

    case (state_q)
      RUN: begin
        if (BranchTaken) begin
          PCWrite   = 1'b1;
          IfIdClear = 1'b1;
          IdExClear = 1'b1;
        end else if (EretInId) begin
          PCSrcOvr  = OVR_EPC;
          IfIdClear = 1'b1;
          ie_d      = 1'b1;
        end else if (stall_run) begin
          PCWrite   = 1'b0;
          IfIdWrite = 1'b0;
          IdExClear = 1'b1;
        end
        if (ie_q && int_any && !BranchTaken && !EretInId && !stall_run) begin
          state_d     = DRAIN;
          drain_cnt_d = 1'b0;
        end
      end

      DRAIN: begin
        // Freeze fetch/decode and feed bubbles so EX and MEM retire.
        PCWrite   = 1'b0;
        IfIdWrite = 1'b0;
        IdExClear = 1'b1;
        if (drain_cnt_q) begin
          state_d     = FLUSH;
          drain_cnt_d = 1'b0;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end

      FLUSH: begin
        if (int_any) begin
          PCWrite     = 1'b0;
          IfIdClear   = 1'b1;
          IdExClear   = 1'b1;
          ExMeClear   = 1'b1;
          EpcWrite    = 1'b1;
          IntCause    = int_win;
          int_cause_d = int_win;
          state_d     = VECT;
        end else begin
          // Request masked off while draining: keep the frozen ID
          // instruction intact and resume normally.
          PCWrite   = 1'b0;
          IfIdWrite = 1'b0;
          IdExClear = 1'b1;
          state_d   = RUN;
        end
      end

      VECT: begin
        PCSrcOvr = OVR_VEC;
        PCWrite  = 1'b1;
        IfIdClear = 1'b1;
        IntAck   = 4'b0001 << int_cause_q;
        ie_d     = 1'b0;
        state_d  = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      PCWrite   = 1'b0;
      IfIdWrite = 1'b0;
      IdExWrite = 1'b0;
      ExMeWrite = 1'b0;
      MeWbWrite = 1'b0;
      IfIdClear = 1'b1;
      IdExClear = 1'b1;
      ExMeClear = 1'b1;
      MeWbClear = 1'b1;
      PCSrcOvr  = OVR_NONE;
      EpcWrite  = 1'b0;
      IntAck    = 4'b0000;
      IntCause  = int_cause_q;
    end

    int_pend_d = (int_pend_q | IntReq) & ~IntAck;
  end

  // State, drain counter, pending lines, cause and IE registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 1'b0;
      int_pend_q  <= 4'b0000;
      int_cause_q <= 2'd0;
      ie_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      int_pend_q  <= int_pend_d;
      int_cause_q <= int_cause_d;
      ie_q        <= ie_d;
    end
  end

  assign IeOut = ie_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of RUN-state hazard vectors plus
// hand-written interrupt entry, ERET, withdrawal and reset-abort sequences.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_LOAD_USE_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  localparam logic [18:0] ALL = 19'h7FFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       LoadInEx;
  logic [4:0] RdEx, RsId, RtId;
  logic       BranchTaken, EretInId;
  logic [3:0] IntReq, IntMask;
  logic       IeWr, IeWrData;
  logic       PCWrite, IfIdWrite, IdExWrite, ExMeWrite, MeWbWrite;
  logic       IfIdClear, IdExClear, ExMeClear, MeWbClear;
  logic [1:0] PCSrcOvr;
  logic       EpcWrite;
  logic [3:0] IntAck;
  logic [1:0] IntCause;
  logic       IeOut;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .LoadInEx(LoadInEx), .RdEx(RdEx), .RsId(RsId),
    .RtId(RtId), .BranchTaken(BranchTaken), .EretInId(EretInId),
    .IntReq(IntReq), .IntMask(IntMask), .IeWr(IeWr), .IeWrData(IeWrData),
    .PCWrite(PCWrite), .IfIdWrite(IfIdWrite), .IdExWrite(IdExWrite),
    .ExMeWrite(ExMeWrite), .MeWbWrite(MeWbWrite), .IfIdClear(IfIdClear),
    .IdExClear(IdExClear), .ExMeClear(ExMeClear), .MeWbClear(MeWbClear),
    .PCSrcOvr(PCSrcOvr), .EpcWrite(EpcWrite), .IntAck(IntAck),
    .IntCause(IntCause), .IeOut(IeOut)
  );

  always #5 clk = ~clk;

  // Pack {IE, cause, writes[5], clears[4], ovr, epc, ack}.
  function automatic logic [18:0] ev(input logic ie, input logic [1:0] c,
                                     input logic [4:0] w, input logic [3:0] cl,
                                     input logic [1:0] ovr, input logic epc,
                                     input logic [3:0] ack);
    return {ie, c, w, cl, ovr, epc, ack};
  endfunction

  function automatic logic [18:0] actual();
    return {IeOut, IntCause, PCWrite, IfIdWrite, IdExWrite, ExMeWrite,
            MeWbWrite, IfIdClear, IdExClear, ExMeClear, MeWbClear,
            PCSrcOvr, EpcWrite, IntAck};
  endfunction

  // Compare on the falling edge, then advance past the next rising edge.
  task automatic step(input logic [18:0] exp, input logic [18:0] msk,
                      input string nm);
    logic [18:0] act;
    @(negedge clk);
    act = actual();
    n_cmp++;
    if ((act & msk) !== (exp & msk)) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (mask %h)", nm, act, exp, msk);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ld;
    logic [4:0]  rd, rs, rt;
    logic        br, er;
    logic [18:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [4:0] sw;
    logic [3:0] sc;
    sw = LU ? 5'b00111 : 5'b11111;
    sc = LU ? 4'b0100  : 4'b0000;

    tbl[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ev(0, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), "t_idle"};
    tbl[1] = '{1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, ev(0, 0, sw, sc, 2'b00, 0, 0), "t_lu_rs_c1"};
    tbl[2] = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, ev(0, 0, sw, sc, 2'b00, 0, 0), "t_lu_rt_c2"};
    tbl[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ev(0, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), "t_lu_r0"};
    tbl[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, ev(0, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), "t_noload"};
    tbl[5] = '{1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, ev(0, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), "t_nomatch"};
    tbl[6] = '{1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, ev(0, 0, 5'b11111, 4'b1100, 2'b00, 0, 0), "t_lu_branch"};
    tbl[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, ev(0, 0, 5'b11111, 4'b1100, 2'b00, 0, 0), "t_branch"};
    tbl[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, ev(0, 0, 5'b11111, 4'b1000, 2'b10, 0, 0), "t_eret"};
    tbl[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, ev(1, 0, 5'b11111, 4'b1100, 2'b00, 0, 0), "t_eret_branch"};

    rst = 1'b1; LoadInEx = 1'b0; RdEx = '0; RsId = '0; RtId = '0;
    BranchTaken = 1'b0; EretInId = 1'b0; IntReq = '0; IntMask = '0;
    IeWr = 1'b0; IeWrData = 1'b0;
    @(posedge clk); #1;

    // Reset held: everything flushed and frozen.
    step(ev(0, 0, 5'b00000, 4'b1111, 2'b00, 0, 0), ALL, "rst_c1");
    step(ev(0, 0, 5'b00000, 4'b1111, 2'b00, 0, 0), ALL, "rst_c2");
    rst = 1'b0;
    step(ev(0, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "rst_release");

    // RUN-state hazard table.
    for (int i = 0; i < 10; i++) begin
      LoadInEx = tbl[i].ld; RdEx = tbl[i].rd; RsId = tbl[i].rs; RtId = tbl[i].rt;
      BranchTaken = tbl[i].br; EretInId = tbl[i].er;
      step(tbl[i].exp, ALL, tbl[i].nm);
    end
    LoadInEx = 1'b0; RdEx = '0; RsId = '0; RtId = '0;
    BranchTaken = 1'b0; EretInId = 1'b0;

    // Two-line pulse: line 1 wins, line 2 stays pending; branch/ERET ignored in DRAIN.
    IntMask = 4'b1111; IntReq = 4'b0110;
    step(ev(1, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "c_pulse");
    IntReq = 4'b0000;
    step(ev(1, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "c_entry");
    BranchTaken = 1'b1;
    step(ev(1, 0, 5'b00111, 4'b0100, 2'b00, 0, 0), ALL, "c_drain0");
    BranchTaken = 1'b0; EretInId = 1'b1;
    step(ev(1, 0, 5'b00111, 4'b0100, 2'b00, 0, 0), ALL, "c_drain1");
    EretInId = 1'b0;
    step(ev(1, 1, 5'b01111, 4'b1110, 2'b00, 1, 0), ALL, "c_flush");
    IeWr = 1'b1; IeWrData = 1'b1;
    step(ev(1, 1, 5'b11111, 4'b1000, 2'b01, 0, 4'b0010), ALL, "c_vect");
    IeWr = 1'b0; IeWrData = 1'b0;
    step(ev(0, 1, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "c_after");
    step(ev(0, 1, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "c_idle");

    // ERET re-enables IE (beating a same-cycle IeWr of 0), line 2 then taken.
    EretInId = 1'b1; IeWr = 1'b1; IeWrData = 1'b0;
    step(ev(0, 1, 5'b11111, 4'b1000, 2'b10, 0, 0), ALL, "d_eret");
    EretInId = 1'b0; IeWr = 1'b0;
    step(ev(1, 1, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "d_entry");
    step(ev(1, 1, 5'b00111, 4'b0100, 2'b00, 0, 0), ALL, "d_drain0");
    step(ev(1, 1, 5'b00111, 4'b0100, 2'b00, 0, 0), ALL, "d_drain1");
    step(ev(1, 2, 5'b01111, 4'b1110, 2'b00, 1, 0), ALL, "d_flush");
    step(ev(1, 2, 5'b11111, 4'b1000, 2'b01, 0, 4'b0100), ALL, "d_vect");
    step(ev(0, 2, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "d_after");

    // Request masked off while draining: no EPC write, no ack, back to RUN.
    IeWr = 1'b1; IeWrData = 1'b1; IntReq = 4'b0001;
    step(ev(0, 2, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "e_pulse");
    IeWr = 1'b0; IntReq = 4'b0000;
    step(ev(1, 2, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "e_entry");
    IntMask = 4'b0000;
    step(ev(1, 2, 5'b00111, 4'b0100, 2'b00, 0, 0), ALL, "e_drain0");
    step(ev(1, 2, 5'b00111, 4'b0100, 2'b00, 0, 0), ALL, "e_drain1");
    step(ev(1, 2, 5'b00000, 4'b0000, 2'b00, 0, 0), 19'h7001F, "e_flush_withdrawn");
    step(ev(1, 2, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "e_back_run");

    // Reset during FLUSH aborts the entry and clears pending state.
    IntMask = 4'b1111;
    step(ev(1, 2, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "f_entry");
    step(ev(1, 2, 5'b00111, 4'b0100, 2'b00, 0, 0), ALL, "f_drain0");
    step(ev(1, 2, 5'b00111, 4'b0100, 2'b00, 0, 0), ALL, "f_drain1");
    rst = 1'b1;
    step(ev(1, 0, 5'b00000, 4'b1111, 2'b00, 0, 0), 19'h4FFFF, "f_rst_in_flush");
    rst = 1'b0;
    step(ev(0, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "f_after");
    IeWr = 1'b1; IeWrData = 1'b1;
    step(ev(0, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, "f_ie_set");
    IeWr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(ev(1, 0, 5'b11111, 4'b0000, 2'b00, 0, 0), ALL, $sformatf("f_idle%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-002 SHALL have LoadInEx input 1: ID/EX instruction is a load.
REQ-003 SHALL have RdEx input 5, RsId input 5, RtId input 5: EX destination, ID sources.
REQ-004 SHALL have BranchTaken input 1: EX resolved a taken branch/jump; EretInId input 1: ID holds ERET.
REQ-005 SHALL have IntReq input 4: level requests, bit 0 highest priority; IntMask input 4: per-line enable.
REQ-006 SHALL have IeWr input 1, IeWrData input 1: coprocessor write of global interrupt enable IE.
REQ-007 SHALL have PCWrite, IfIdWrite, IdExWrite, ExMeWrite, MeWbWrite outputs 1 each: stage write enables.
REQ-008 SHALL have IfIdClear, IdExClear, ExMeClear, MeWbClear outputs 1 each: stage flush requests.
REQ-009 SHALL have PCSrcOvr output 2 (00 none, 01 vector, 10 EPC), EpcWrite output 1, IntAck output 4 one-hot, IntCause output 2, IeOut output 1.

Function
REQ-010 SHALL implement FSM states RUN, DRAIN, FLUSH, VECT; outputs combinational from state, counters and inputs, stable before falling clk edge.
REQ-011 SHALL hold pending register IntPend[3:0]: IntPend <= (IntPend | IntReq) & ~IntAck each cycle.
REQ-012 RUN defaults: all Write=1, all Clear=0, PCSrcOvr=00, EpcWrite=0, IntAck=0.
REQ-013 RUN load-use: LoadInEx=1, RdEx!=0, RdEx==RsId or RdEx==RtId -> PCWrite=0, IfIdWrite=0, IdExClear=1; persists while condition holds.
REQ-014 RUN BranchTaken=1 -> IfIdClear=1, IdExClear=1, PCWrite=1; overrides load-use (no stall that cycle).
REQ-015 RUN EretInId=1 and BranchTaken=0 -> PCSrcOvr=10, IfIdClear=1; IE<=1 at next edge.
REQ-016 RUN entry: IE=1, (IntPend&IntMask)!=0, BranchTaken=0, EretInId=0, no load-use stall -> DRAIN next edge, drain counter <=0.
REQ-017 DRAIN: PCWrite=0, IfIdWrite=0, IdExClear=1, others Write=1; stays exactly 2 cycles (counter 0,1) so EX/MEM instructions retire; then FLUSH.
REQ-018 FLUSH (1 cycle): IfIdClear=1, IdExClear=1, ExMeClear=1, PCWrite=0, EpcWrite=1; winner = lowest set bit of IntPend&IntMask latched to IntCause; then VECT.
REQ-019 FLUSH winner mask empty (request withdrawn by mask change): EpcWrite=0, return RUN, no ack.
REQ-020 VECT (1 cycle): PCSrcOvr=01, PCWrite=1, IfIdClear=1, IntAck=one-hot(IntCause), IE<=0; then RUN.
REQ-021 IeWr=1 sets IE<=IeWrData at next edge; ERET write (REQ-015) and VECT clear take priority over IeWr same cycle.
REQ-022 BranchTaken or EretInId during DRAIN/FLUSH/VECT SHALL be ignored (instruction flushed).
REQ-023 IeOut SHALL equal IE register.

Reset
REQ-024 rst=1 at clock edge: state<=RUN, counter<=0, IntPend<=0, IntCause<=0, IE<=0.
REQ-025 While rst=1 outputs: all Write=0, all Clear=1, PCSrcOvr=00, EpcWrite=0, IntAck=0, regardless of state.
REQ-026 rst mid-sequence (DRAIN/FLUSH/VECT) SHALL abort with no IntAck and no EpcWrite after reset.

Configuration
REQ-027 Macro PIPE_CTRL_LOAD_USE_EN defined: REQ-013 active; undefined: load-use stall logic absent, LoadInEx/RdEx/RsId/RtId ignored, entry condition omits stall term.

Verification
REQ-028 rst 2 cycles then release -> all Clear=1/Write=0 during rst; RUN, IE=0, IntAck=0 after.
REQ-029 LoadInEx=1, RdEx=5, RsId=5, 2 cycles -> PCWrite=0, IfIdWrite=0, IdExClear=1 both cycles; RdEx=0 -> no stall.
REQ-030 load-use and BranchTaken=1 same cycle -> IfIdClear=1, IdExClear=1, PCWrite=1.
REQ-031 IE=1, IntMask=4'b1111, IntReq=4'b0110 pulse 1 cycle -> DRAIN 2, FLUSH (EpcWrite=1, IntCause=1), VECT (PCSrcOvr=01, IntAck=4'b0010), IE=0, IntPend=4'b0100.
REQ-032 EretInId=1 in RUN with IntPend=4'b0100 -> PCSrcOvr=10, IfIdClear=1; next cycle IE=1, then entry, IntAck=4'b0100 after 4 cycles.
REQ-033 rst asserted in FLUSH -> no EpcWrite/IntAck after; IntPend=0, state RUN.
